// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the single-wire serial link.
//   state_e     - transmitter FSM states (PARITY used only when SERIAL_TX_PARITY_EN is defined)
//   IDLE_LEVEL  - level of the line between frames
//   frame_len() - clocks per frame for a given word width, bit time and parity setting;
//                 used by both ends of the link and by the bench
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned clks_per_bit,
                                              input bit          parity_en);
        return (data_w + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts the clocks of one serial bit.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart the count at 0 (frame accepted)
//   enable     - count while a frame is in progress
//   bit_end    - high on the last clock of the current bit (count == CLKS_PER_BIT-1)
// The count wraps to 0 on bit_end, so each following state starts from 0 without a clear.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Frame: start bit (0), DATA_W data bits LSB first, optional even-parity bit, stop bit (1);
// every bit lasts CLKS_PER_BIT clocks. Build option: define SERIAL_TX_PARITY_EN to insert
// the parity bit.
//   clk, rst_n - clock, asynchronous active-low reset
//   tx_valid   - tx_data holds a word to send
//   tx_ready   - high only in IDLE; a word is taken on an edge where tx_valid && tx_ready
//   tx_data    - word to send, captured at acceptance
//   tx         - serial line (registered, idle high)
//   busy       - frame in progress
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | start bit (line low)
// DATA   | data bit idx_q on the line, LSB first
// PARITY | even-parity bit (SERIAL_TX_PARITY_EN builds only)
// STOP   | stop bit (line high), then back to IDLE
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              ready_q, ready_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              accept;
    logic              bit_end;
    logic [DATA_W-1:0] shift_nxt;

    assign accept    = (state_q == IDLE) && tx_valid;
    assign shift_nxt = shift_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q != IDLE),
        .bit_end(bit_end)
    );

    // Outputs are computed from the next state so that tx/busy/tx_ready change on the
    // same edge as the state and come straight from flops.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_nxt;
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_nxt[0];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;

endmodule
